// File: rtl/pool_ctrl.sv
// rtl/pool_ctrl.sv - max-pooling sequencer: feature read walk, line-buffer/pool enables, output writes
// Optional stall input enabled by defining POOL_STALL_EN.
module pool_ctrl #(
  parameter int DWIDTH   = 16,
  parameter int LWIDTH   = 10,
  parameter int MEMWIDTH = 12,
  parameter int PSIZE    = 2,
  parameter int BUF_LAT  = 1,
  parameter int POOL_LAT = 2
) (
  input  logic                clk,
  input  logic                xrst,
  input  logic                req,
  input  logic [LWIDTH-1:0]   total_out,
  input  logic [LWIDTH-1:0]   fea_size,
  input  logic [MEMWIDTH-1:0] in_offset,
  input  logic [MEMWIDTH-1:0] out_offset,
`ifdef POOL_STALL_EN
  input  logic                stall,
`endif
  output logic                ack,
  output logic                busy,
  output logic [MEMWIDTH-1:0] mem_feat_addr,
  output logic                buf_feat_en,
  output logic [LWIDTH-1:0]   w_fea_size,
  output logic [LWIDTH-1:0]   w_pool_size,
  output logic                out_en,
  output logic                mem_out_we,
  output logic [MEMWIDTH-1:0] mem_out_addr
);

  localparam int PL = 1 + BUF_LAT + POOL_LAT;

  if (PSIZE != 2 || DWIDTH < 1 || BUF_LAT < 1 || POOL_LAT < 1) begin : g_cfg_err
    $error("pool_ctrl: unsupported parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_READ, S_DRAIN, S_NEXT, S_DONE} state_t;

  state_t            state;
  logic [LWIDTH-1:0] total_q;
  logic [LWIDTH-1:0] ch;
  logic [LWIDTH-1:0] row;
  logic [LWIDTH-1:0] col;
  logic [LWIDTH-1:0] last_idx;
  logic [PL-1:0]     pv;
  logic [PL-1:0]     pt;
  logic              buf_q;
  logic              hold;
  logic              rd;
  logic              win;

`ifdef POOL_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  assign rd          = (state == S_READ) && !hold;
  // Odd row and odd col closes a 2x2 window; an odd map's trailing row/col index is even.
  assign win         = row[0] & col[0];
  assign last_idx    = (w_fea_size == '0) ? '0 : w_fea_size - LWIDTH'(1);
  assign w_pool_size = LWIDTH'(PSIZE);
  assign buf_feat_en = buf_q;
  assign out_en      = pt[BUF_LAT] & !hold;
  assign mem_out_we  = pt[PL-1] & !hold;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state         <= S_IDLE;
      total_q       <= '0;
      ch            <= '0;
      row           <= '0;
      col           <= '0;
      pv            <= '0;
      pt            <= '0;
      buf_q         <= 1'b0;
      ack           <= 1'b0;
      busy          <= 1'b0;
      mem_feat_addr <= '0;
      mem_out_addr  <= '0;
      w_fea_size    <= '0;
    end else begin
      ack   <= 1'b0;
      buf_q <= rd;
      // pv tracks every issued read, pt only window-completing ones.
      if (!hold) begin
        pv <= {pv[PL-2:0], rd};
        pt <= {pt[PL-2:0], rd & win};
      end
      if (mem_out_we) mem_out_addr <= mem_out_addr + MEMWIDTH'(1);
      if (!hold) begin
        case (state)
          S_IDLE: begin
            if (req) begin
              state <= S_PREP;
              busy  <= 1'b1;
            end
          end
          S_PREP: begin
            total_q       <= total_out;
            w_fea_size    <= fea_size;
            mem_feat_addr <= in_offset;
            mem_out_addr  <= out_offset;
            ch            <= '0;
            row           <= '0;
            col           <= '0;
            if (total_out == '0) begin
              state <= S_DONE;
              ack   <= 1'b1;
            end else begin
              state <= S_READ;
            end
          end
          S_READ: begin
            mem_feat_addr <= mem_feat_addr + MEMWIDTH'(1);
            if (col == last_idx) begin
              col <= '0;
              if (row == last_idx) begin
                row   <= '0;
                state <= S_DRAIN;
              end else begin
                row <= row + LWIDTH'(1);
              end
            end else begin
              col <= col + LWIDTH'(1);
            end
          end
          S_DRAIN: begin
            // Leave once only the final write stage can still be occupied.
            if (pv[PL-2:0] == '0) state <= S_NEXT;
          end
          S_NEXT: begin
            ch <= ch + LWIDTH'(1);
            if (ch + LWIDTH'(1) == total_q) begin
              state <= S_DONE;
              ack   <= 1'b1;
            end else begin
              state <= S_READ;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
